// File: rtl/fetch_decode_if.sv
// Signal bundle between the fetch/decode stage, instruction memory, branch resolution
// and the downstream register-file/ALU datapath.
interface fetch_decode_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  func7;
  logic [31:0] imm;
  logic        reg_write;
  logic        illegal;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and the payload is held stable while valid=1 and ready=0.
  // imem_resp_valid has no ready: the stage always takes the word while it is waiting.
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc,
    output dec_valid, pc_out, opcode, rd, func3, rs1, rs2, func7, imm, reg_write, illegal,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc,
    input  dec_valid, pc_out, opcode, rd, func3, rs1, rs2, func7, imm, reg_write, illegal,
    output dec_ready
  );
endinterface

// File: rtl/fetch_decode.sv
// RV32I fetch and decode stage: one outstanding fetch, registered decode output,
// and PC redirect with squash of an in-flight fetch.
module fetch_decode #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  fetch_decode_if.master     bus,
  output logic [1:0]         dbg_state_o
);

  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        dec_valid_q, dec_valid_d;
  logic        capture;
  logic [31:0] redir_pc;

  logic [31:0] inst_q;
  logic [31:0] pc_out_q;
  logic [31:0] imm_q, imm_d;
  logic        reg_write_q, reg_write_d;
  logic        illegal_q, illegal_d;

  assign redir_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  // Immediate / control decode straight off the returning memory word.
  logic [31:0] inst;
  logic [6:0]  op;
  assign inst = bus.imem_resp_data;
  assign op   = inst[6:0];

  always_comb begin
    imm_d       = 32'd0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        imm_d       = {{20{inst[31]}}, inst[31:20]};
        reg_write_d = 1'b1;
      end
      7'b0100011: imm_d = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'b1100011: imm_d = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b0110111, 7'b0010111: begin
        imm_d       = {inst[31:12], 12'd0};
        reg_write_d = 1'b1;
      end
      7'b1101111: begin
        imm_d       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        reg_write_d = 1'b1;
      end
      7'b0110011: reg_write_d = 1'b1;
      default:    illegal_d   = 1'b1;
    endcase
    if (inst[11:7] == 5'd0) reg_write_d = 1'b0;
  end

  // Next-state logic; a redirect always wins over the normal flow of the current state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    dec_valid_d = dec_valid_q;
    capture     = 1'b0;
    case (state_q)
      S_REQ: begin
        if (bus.redirect_valid)      pc_d    = redir_pc;
        else if (bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.redirect_valid) begin
          pc_d = redir_pc;
          if (bus.imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d  = 1'b1;
          end
        end else if (bus.imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            capture     = 1'b1;
            pc_d        = pc_q + 32'd4;
            dec_valid_d = 1'b1;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.redirect_valid) begin
          pc_d        = redir_pc;
          dec_valid_d = 1'b0;
          state_d     = S_REQ;
        end else if (bus.dec_ready) begin
          dec_valid_d = 1'b0;
          state_d     = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      dec_valid_q <= 1'b0;
      inst_q      <= 32'd0;
      pc_out_q    <= 32'd0;
      imm_q       <= 32'd0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      dec_valid_q <= dec_valid_d;
      if (capture) begin
        inst_q      <= inst;
        pc_out_q    <= pc_q;
        imm_q       <= imm_d;
        reg_write_q <= reg_write_d;
        illegal_q   <= illegal_d;
      end
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ) && !bus.redirect_valid && !reset;
  assign bus.imem_req_addr  = pc_q;
  assign bus.dec_valid      = dec_valid_q;
  assign bus.pc_out         = pc_out_q;
  assign bus.opcode         = inst_q[6:0];
  assign bus.rd             = inst_q[11:7];
  assign bus.func3          = inst_q[14:12];
  assign bus.rs1            = inst_q[19:15];
  assign bus.rs2            = inst_q[24:20];
  assign bus.func7          = inst_q[31:25];
  assign bus.imm            = imm_q;
  assign bus.reg_write      = reg_write_q;
  assign bus.illegal        = illegal_q;
  assign dbg_state_o        = state_q;

endmodule
